fb_write_ctrl: RTL and testbench
================================

Name: fb_write_ctrl

Overview:
Sequences CPU-side framebuffer writes for the LED panel. It sits between the Nios PIO ports (write address, write data, out-flags and in-flags) and the write port of a double-buffered 24-bit RGB framebuffer RAM. It turns toggle handshakes on the PIO flags into RAM write cycles, a back-buffer clear sweep and a frame-synchronous bank swap. The panel scan engine reads the front bank.

Parameters:
ADDR_W, 12, pixel address width per bank (matches the PIO write-address width)
DATA_W, 24, pixel width (8:8:8 RGB; matches the PIO write-data width)

Ports:
clk_clk  in  1  system clock
reset_reset  in  1  synchronous reset, active-high
wr_addr  in  ADDR_W  pixel address from the address PIO
wr_data  in  DATA_W  pixel data from the data PIO
wr_out_flags  in  8  request toggles from the CPU: [0] WR_TGL, [1] SWAP_TGL, [2] CLR_TGL, [7:3] ignored
wr_in_flags  out  8  status to the CPU: [0] WR_ACK, [1] SWAP_ACK, [2] CLR_ACK, [3] busy, [4] front_bank, [7:5] 0
frame_end  in  1  one-cycle pulse from the scan engine at end of frame
fb_we  out  1  framebuffer write enable
fb_addr  out  ADDR_W+1  framebuffer address; MSB is the bank bit
fb_wdata  out  DATA_W  framebuffer write data
front_bank  out  1  bank currently displayed
busy  out  1  FSM not in IDLE

Behaviour:
- Single clock domain. The PIO is on clk_clk, so no synchronisers.
- Request i is pending while wr_out_flags[i] != ack[i]. The CPU toggles a flag to request and polls until the matching ack equals it.
- Reset (synchronous, any state, including mid-clear or mid-swap-wait):
  - state IDLE, all acks 0, front_bank 0, fb_we 0, fb_addr 0, fb_wdata 0, busy 0, clear counter 0, wr_in_flags 8'h00.
  - Interrupted operations are abandoned and never acked.
- Back bank = ~front_bank. All writes target the back bank only.
- FSM states: IDLE, WRITE, ACK_WR, CLEAR, SWAP_WAIT.
- IDLE arbitration, fixed priority WR > CLR > SWAP; one request is accepted per IDLE cycle.
- WR path:
  - Accepting cycle: latch {~front_bank, wr_addr} and wr_data, go to WRITE.
  - WRITE: fb_we=1 for exactly one cycle with the latched address/data; toggle ack[0]; go to ACK_WR.
  - ACK_WR: one idle cycle so the compare sees the new ack; go to IDLE.
  - fb_we rises 1 cycle after acceptance; back in IDLE 3 cycles after acceptance.
- CLR path:
  - Accepting cycle: latch wr_data as the fill value, counter=0, go to CLEAR.
  - CLEAR: fb_we=1 every cycle, fb_addr={~front_bank, counter}, counter increments.
  - On counter = 2^ADDR_W-1 that write is the last; toggle ack[2], go to IDLE.
  - A clear takes exactly 2^ADDR_W write cycles (4096 at default). The counter does not wrap.
- SWAP path:
  - Accepting cycle: go to SWAP_WAIT.
  - frame_end is sampled only in SWAP_WAIT. A frame_end in the accepting cycle or in IDLE is ignored.
  - On frame_end in SWAP_WAIT: front_bank toggles and ack[1] toggles on the same edge; go to IDLE.
- Requests arriving while the FSM is not in IDLE stay pending and are served later by priority. A WR during SWAP_WAIT therefore lands in the new back bank after the swap.
- The CPU re-toggling a flag before its ack returns cancels the request (levels equal again). This is CPU misuse; the block only has to stay consistent.
- fb_we is 0 in every state except WRITE and CLEAR. fb_addr/fb_wdata hold their last values when fb_we=0.
- busy = (state != IDLE). wr_in_flags = {3'b0, front_bank, busy, ack[2:0]}, all registered.

Optional Feature:
FBWC_CLEAR_EN
- Defined: CLR path, CLEAR state and ADDR_W-bit counter are present as described.
- Undefined: CLR_TGL is ignored, wr_in_flags[2] is constant 0, and no counter or CLEAR state is synthesised. WR > SWAP priority is unchanged.

Test Plan:
- Reset, toggle WR_TGL with wr_addr=12'h123, wr_data=24'hFF8000 -> fb_we=1 for one cycle 1 cycle later, fb_addr=13'h1123, fb_wdata=24'hFF8000; wr_in_flags[0]=1 on the following cycle; busy high for 2 cycles.
- Toggle SWAP_TGL, pulse frame_end 10 cycles later -> front_bank 0->1 and wr_in_flags[1]=1 on that edge. Then WR to 12'h005 -> fb_addr=13'h0005.
- Toggle SWAP_TGL and WR_TGL in the same cycle -> WR served first (fb_we, ack[0]), then SWAP_WAIT; a frame_end during WRITE is ignored and only the next frame_end swaps.
- (FBWC_CLEAR_EN) Toggle CLR_TGL with wr_data=24'h000010 -> exactly 4096 consecutive fb_we cycles at addresses 13'h1000..13'h1FFF with data 24'h000010; ack[2] toggles on the last; a WR toggled mid-clear is served right after.
- Assert reset_reset at clear counter 2000 -> next cycle fb_we=0, wr_in_flags=8'h00, front_bank=0; no further writes until a new request.
- Without FBWC_CLEAR_EN, toggle CLR_TGL -> no fb_we, wr_in_flags[2] stays 0, busy stays 0.

Source files
------------

// File: rtl/fb_write_ctrl.sv
// fb_write_ctrl: PIO toggle handshakes to framebuffer writes and bank swaps.
// Back-bank clear sweep is built only when FBWC_CLEAR_EN is defined.
module fb_write_ctrl #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 24
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [7:0]        wr_out_flags,
    output logic [7:0]        wr_in_flags,
    input  logic              frame_end,
    output logic              fb_we,
    output logic [ADDR_W:0]   fb_addr,
    output logic [DATA_W-1:0] fb_wdata,
    output logic              front_bank,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WRITE     = 3'd1,
        ACK_WR    = 3'd2,
`ifdef FBWC_CLEAR_EN
        CLEAR     = 3'd3,
`endif
        SWAP_WAIT = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [2:0]        ack_q, ack_d;
    logic              front_q, front_d;
    logic              busy_q, busy_d;
    logic              we_q, we_d;
    logic [ADDR_W:0]   addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic [2:0] pend;
    logic       gnt_wr;
    logic       gnt_swap;
    logic       unused_flags;

    assign pend   = wr_out_flags[2:0] ^ ack_q;
    assign gnt_wr = pend[0];

`ifdef FBWC_CLEAR_EN
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              gnt_clr;

    assign gnt_clr      = pend[2] & ~pend[0];
    assign gnt_swap     = pend[1] & ~pend[0] & ~pend[2];
    assign unused_flags = ^wr_out_flags[7:3];
`else
    assign gnt_swap     = pend[1] & ~pend[0];
    assign unused_flags = ^{wr_out_flags[7:3], pend[2]};
`endif

    // Next-state, handshake and write-port sequencing
    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        front_d = front_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef FBWC_CLEAR_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                unique case (1'b1)
                    gnt_wr: begin
                        state_d = WRITE;
                        addr_d  = {~front_q, wr_addr};
                        wdata_d = wr_data;
                    end
`ifdef FBWC_CLEAR_EN
                    gnt_clr: begin
                        state_d = CLEAR;
                        cnt_d   = '0;
                        addr_d  = {~front_q, {ADDR_W{1'b0}}};
                        wdata_d = wr_data;
                    end
`endif
                    gnt_swap: begin
                        state_d = SWAP_WAIT;
                    end
                    default: ;
                endcase
            end
            WRITE: begin
                ack_d[0] = ~ack_q[0];
                state_d  = ACK_WR;
            end
            ACK_WR: begin
                state_d = IDLE;
            end
`ifdef FBWC_CLEAR_EN
            CLEAR: begin
                if (cnt_q == '1) begin
                    ack_d[2] = ~ack_q[2];
                    state_d  = IDLE;
                end else begin
                    cnt_d  = cnt_q + ADDR_W'(1);
                    addr_d = {~front_q, cnt_d};
                end
            end
`endif
            SWAP_WAIT: begin
                if (frame_end) begin
                    front_d  = ~front_q;
                    ack_d[1] = ~ack_q[1];
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
`ifdef FBWC_CLEAR_EN
        we_d   = (state_d == WRITE) || (state_d == CLEAR);
`else
        we_d   = (state_d == WRITE);
`endif
    end

    // State and registered outputs, synchronous reset
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q <= IDLE;
            ack_q   <= '0;
            front_q <= 1'b0;
            busy_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef FBWC_CLEAR_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            front_q <= front_d;
            busy_q  <= busy_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
`ifdef FBWC_CLEAR_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign fb_we       = we_q;
    assign fb_addr     = addr_q;
    assign fb_wdata    = wdata_q;
    assign front_bank  = front_q;
    assign busy        = busy_q;
    assign wr_in_flags = {3'b000, front_q, busy_q, ack_q};

endmodule

// File: tb/tb_fb_write_ctrl.sv
// tb_fb_write_ctrl: directed bench for fb_write_ctrl.
// Clear scenarios are compiled in when FBWC_CLEAR_EN is defined.
module tb_fb_write_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] wr_addr = '0;
    logic [23:0] wr_data = '0;
    logic [7:0]  flags = '0;
    logic [7:0]  in_flags;
    logic        frame_end = 1'b0;
    logic        fb_we;
    logic [12:0] fb_addr;
    logic [23:0] fb_wdata;
    logic        front;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    fb_write_ctrl dut (
        .clk_clk      (clk),
        .reset_reset  (rst),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_out_flags (flags),
        .wr_in_flags  (in_flags),
        .frame_end    (frame_end),
        .fb_we        (fb_we),
        .fb_addr      (fb_addr),
        .fb_wdata     (fb_wdata),
        .front_bank   (front),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_frame_end();
        frame_end = 1'b1;
        step();
        frame_end = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        flags = '0;
        step();
        step();
        rst = 1'b0;
        step();
        n_checks++;
        if (fb_we !== 1'b0) $display("FAIL rst_we got %b exp 0", fb_we);
        else n_pass++;
        n_checks++;
        if (fb_addr !== 13'h0000) $display("FAIL rst_addr got %h exp 0000", fb_addr);
        else n_pass++;
        n_checks++;
        if (fb_wdata !== 24'h0) $display("FAIL rst_wdata got %h exp 0", fb_wdata);
        else n_pass++;
        n_checks++;
        if (in_flags !== 8'h00) $display("FAIL rst_flags got %h exp 00", in_flags);
        else n_pass++;
        n_checks++;
        if (front !== 1'b0 || busy !== 1'b0)
            $display("FAIL rst_front_busy got %b%b exp 00", front, busy);
        else n_pass++;
    endtask

    task automatic test_wr();
        wr_addr = 12'h123;
        wr_data = 24'hFF8000;
        flags[0] = ~flags[0];
        step();
        n_checks++;
        if (fb_we !== 1'b1) $display("FAIL wr_we got %b exp 1", fb_we);
        else n_pass++;
        n_checks++;
        if (fb_addr !== 13'h1123) $display("FAIL wr_addr got %h exp 1123", fb_addr);
        else n_pass++;
        n_checks++;
        if (fb_wdata !== 24'hFF8000) $display("FAIL wr_data got %h exp ff8000", fb_wdata);
        else n_pass++;
        n_checks++;
        if (in_flags !== 8'h08) $display("FAIL wr_busy1 got %h exp 08", in_flags);
        else n_pass++;
        step();
        n_checks++;
        if (fb_we !== 1'b0) $display("FAIL wr_we_1cyc got %b exp 0", fb_we);
        else n_pass++;
        n_checks++;
        if (in_flags !== 8'h09) $display("FAIL wr_ack got %h exp 09", in_flags);
        else n_pass++;
        n_checks++;
        if (fb_addr !== 13'h1123) $display("FAIL wr_addr_hold got %h exp 1123", fb_addr);
        else n_pass++;
        step();
        n_checks++;
        if (in_flags !== 8'h01) $display("FAIL wr_idle got %h exp 01", in_flags);
        else n_pass++;
    endtask

    task automatic test_swap();
        pulse_frame_end();
        n_checks++;
        if (front !== 1'b0 || busy !== 1'b0)
            $display("FAIL swap_idle_fe got %b%b exp 00", front, busy);
        else n_pass++;
        flags[1] = ~flags[1];
        pulse_frame_end();
        n_checks++;
        if (in_flags !== 8'h09) $display("FAIL swap_accept got %h exp 09", in_flags);
        else n_pass++;
        repeat (9) step();
        n_checks++;
        if (front !== 1'b0 || busy !== 1'b1)
            $display("FAIL swap_wait got %b%b exp 01", front, busy);
        else n_pass++;
        pulse_frame_end();
        n_checks++;
        if (in_flags !== 8'h13) $display("FAIL swap_done got %h exp 13", in_flags);
        else n_pass++;
        step();
        n_checks++;
        if (front !== 1'b1) $display("FAIL swap_hold got %b exp 1", front);
        else n_pass++;
        wr_addr = 12'h005;
        wr_data = 24'h0000FF;
        flags[0] = ~flags[0];
        step();
        n_checks++;
        if (fb_we !== 1'b1 || fb_addr !== 13'h0005)
            $display("FAIL swap_wr got we=%b addr=%h exp 1 0005", fb_we, fb_addr);
        else n_pass++;
        step();
        step();
        n_checks++;
        if (in_flags !== 8'h12) $display("FAIL swap_wr_ack got %h exp 12", in_flags);
        else n_pass++;
    endtask

    task automatic test_wr_then_swap();
        wr_addr = 12'h7FF;
        wr_data = 24'h00AA55;
        flags[0] = ~flags[0];
        flags[1] = ~flags[1];
        step();
        n_checks++;
        if (fb_we !== 1'b1 || fb_addr !== 13'h07FF || fb_wdata !== 24'h00AA55)
            $display("FAIL prio_wr got we=%b addr=%h data=%h exp 1 07ff 00aa55",
                     fb_we, fb_addr, fb_wdata);
        else n_pass++;
        pulse_frame_end();
        n_checks++;
        if (fb_we !== 1'b0 || front !== 1'b1)
            $display("FAIL prio_fe_in_write got we=%b front=%b exp 0 1", fb_we, front);
        else n_pass++;
        step();
        n_checks++;
        if (in_flags !== 8'h13) $display("FAIL prio_ackwr got %h exp 13", in_flags);
        else n_pass++;
        step();
        n_checks++;
        if (in_flags !== 8'h1B) $display("FAIL prio_swapwait got %h exp 1b", in_flags);
        else n_pass++;
        repeat (3) step();
        n_checks++;
        if (front !== 1'b1 || fb_we !== 1'b0)
            $display("FAIL prio_hold got front=%b we=%b exp 1 0", front, fb_we);
        else n_pass++;
        pulse_frame_end();
        n_checks++;
        if (in_flags !== 8'h01) $display("FAIL prio_swap got %h exp 01", in_flags);
        else n_pass++;
    endtask

`ifndef FBWC_CLEAR_EN
    task automatic test_clr_ignored();
        int bad;
        bad = 0;
        wr_data = 24'h000010;
        flags[2] = ~flags[2];
        for (int i = 0; i < 4; i++) begin
            step();
            if (fb_we !== 1'b0 || in_flags !== 8'h01) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL clr_off got %0d bad cycles exp 0", bad);
        else n_pass++;
        wr_addr = 12'h321;
        wr_data = 24'h0F0F0F;
        flags[0] = ~flags[0];
        step();
        n_checks++;
        if (fb_we !== 1'b1 || fb_addr !== 13'h1321 || fb_wdata !== 24'h0F0F0F)
            $display("FAIL clr_off_wr got we=%b addr=%h data=%h exp 1 1321 0f0f0f",
                     fb_we, fb_addr, fb_wdata);
        else n_pass++;
        step();
        step();
        n_checks++;
        if (in_flags !== 8'h00) $display("FAIL clr_off_ack got %h exp 00", in_flags);
        else n_pass++;
    endtask
`else
    task automatic test_clear();
        int bad;
        bad = 0;
        wr_data = 24'h000010;
        flags[2] = ~flags[2];
        step();
        for (int i = 0; i < 4096; i++) begin
            if (fb_we !== 1'b1 || fb_addr !== {1'b1, 12'(i)} ||
                fb_wdata !== 24'h000010 || in_flags[2] !== 1'b0) begin
                if (bad < 3)
                    $display("FAIL clr_sweep i=%0d got we=%b addr=%h data=%h",
                             i, fb_we, fb_addr, fb_wdata);
                bad++;
            end
            if (i == 100) begin
                wr_addr = 12'h0AA;
                wr_data = 24'h123456;
                flags[0] = ~flags[0];
            end
            step();
        end
        n_checks++;
        if (bad != 0) $display("FAIL clr_sweep got %0d bad cycles exp 0", bad);
        else n_pass++;
        n_checks++;
        if (fb_we !== 1'b0 || in_flags !== 8'h05)
            $display("FAIL clr_done got we=%b flags=%h exp 0 05", fb_we, in_flags);
        else n_pass++;
        step();
        n_checks++;
        if (fb_we !== 1'b1 || fb_addr !== 13'h10AA || fb_wdata !== 24'h123456)
            $display("FAIL clr_then_wr got we=%b addr=%h data=%h exp 1 10aa 123456",
                     fb_we, fb_addr, fb_wdata);
        else n_pass++;
        step();
        step();
        n_checks++;
        if (in_flags !== 8'h04) $display("FAIL clr_wr_ack got %h exp 04", in_flags);
        else n_pass++;
    endtask

    task automatic test_reset_mid_clear();
        int bad;
        bad = 0;
        wr_data = 24'h00FF00;
        flags[2] = ~flags[2];
        step();
        for (int i = 0; i <= 2000; i++) begin
            if (fb_we !== 1'b1 || fb_addr !== {1'b1, 12'(i)}) bad++;
            if (i != 2000) step();
        end
        n_checks++;
        if (bad != 0) $display("FAIL rclr_sweep got %0d bad cycles exp 0", bad);
        else n_pass++;
        rst = 1'b1;
        flags = '0;
        step();
        rst = 1'b0;
        n_checks++;
        if (fb_we !== 1'b0 || in_flags !== 8'h00 || front !== 1'b0)
            $display("FAIL rclr_reset got we=%b flags=%h front=%b exp 0 00 0",
                     fb_we, in_flags, front);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (fb_we !== 1'b0 || in_flags !== 8'h00) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL rclr_quiet got %0d bad cycles exp 0", bad);
        else n_pass++;
    endtask
`endif

    task automatic test_reset_mid_swap();
        flags[1] = ~flags[1];
        step();
        pulse_frame_end();
        n_checks++;
        if (front !== 1'b1) $display("FAIL rswap_pre got %b exp 1", front);
        else n_pass++;
        flags[1] = ~flags[1];
        step();
        n_checks++;
        if (busy !== 1'b1) $display("FAIL rswap_wait got %b exp 1", busy);
        else n_pass++;
        step();
        step();
        rst = 1'b1;
        flags = '0;
        step();
        rst = 1'b0;
        n_checks++;
        if (in_flags !== 8'h00 || front !== 1'b0 || fb_we !== 1'b0)
            $display("FAIL rswap_reset got flags=%h front=%b we=%b exp 00 0 0",
                     in_flags, front, fb_we);
        else n_pass++;
        n_checks++;
        if (fb_addr !== 13'h0 || fb_wdata !== 24'h0)
            $display("FAIL rswap_port got addr=%h data=%h exp 0 0", fb_addr, fb_wdata);
        else n_pass++;
        pulse_frame_end();
        step();
        n_checks++;
        if (in_flags !== 8'h00) $display("FAIL rswap_abandon got %h exp 00", in_flags);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_wr();
        test_swap();
        test_wr_then_swap();
`ifndef FBWC_CLEAR_EN
        test_clr_ignored();
`else
        test_clear();
`endif
        test_reset_mid_swap();
`ifdef FBWC_CLEAR_EN
        test_reset_mid_clear();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
